generic_struct_unpacker: RTL and testbench

- Receive side of the team's struct serial link. It rebuilds one packed two-field struct (d0 in the upper bits, d1 in the lower bits) from a stream of LANE_W-bit beats.
- The beats are produced by the matching serializer on the transmit side.
- The block sits between a narrow serial lane and consumers that use the generic-package struct type.
- It checks frame length against the i_last marker, drops malformed frames and keeps a count of good frames.

---
 rtl/generic_struct_unpacker_pkg.sv | 29 ++
 rtl/generic_struct_unpacker_beat_counter.sv | 33 +++
 rtl/generic_struct_unpacker.sv | 137 +++++++++++++
 tb/tb_generic_struct_unpacker.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/generic_struct_unpacker_pkg.sv
// Shared definitions for the struct serial link: field layout, beat count
// and unpacker state encoding, used by both the serializer and the unpacker.
package generic_struct_unpacker_pkg;

  localparam int DEF_W0     = 1;
  localparam int DEF_W1     = 2;
  localparam int DEF_LANE_W = 1;

  // d0 is declared first so it lands in the upper bits of the packed vector.
  typedef struct packed {
    logic [DEF_W0-1:0] d0;
    logic [DEF_W1-1:0] d1;
  } gs_struct_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DISCARD = 2'd1,
    ST_FULL    = 2'd2
  } unpack_state_e;

  function automatic int calc_beats(input int total_w, input int lane_w);
    return (total_w + lane_w - 1) / lane_w;
  endfunction

  function automatic int cnt_width(input int beats);
    return (beats < 2) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/generic_struct_unpacker_beat_counter.sv
// Modulo-BEATS beat counter with synchronous clear; flags the final beat slot.
module struct_beat_counter
  import generic_struct_unpacker_pkg::*;
#(
  parameter  int BEATS = 3,
  localparam int CW    = cnt_width(BEATS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt,
  output logic          o_is_last
);

  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_is_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/generic_struct_unpacker.sv
// Receive side of the struct serial link: rebuilds {d0, d1} from LSB-first
// beats, drops frames whose i_last disagrees with the beat count.
module generic_struct_unpacker
  import generic_struct_unpacker_pkg::*;
#(
  parameter int W0     = DEF_W0,
  parameter int W1     = DEF_W1,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [LANE_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W0-1:0]     o_d0,
  output logic [W1-1:0]     o_d1,
  output logic              o_err,
  output logic [15:0]       o_frame_cnt
);

  localparam int FW    = W0 + W1;
  localparam int BEATS = calc_beats(FW, LANE_W);
  localparam int BUF_W = BEATS * LANE_W;
  localparam int CW    = cnt_width(BEATS);

  typedef struct packed {
    logic [W0-1:0] d0;
    logic [W1-1:0] d1;
  } field_t;

  // Handshakes: a beat moves on a cycle with i_valid && o_ready; a struct
  // moves on a cycle with o_valid && i_ready. Neither side may retract
  // valid or change payload until its handshake completes.

  unpack_state_e   r_state;
  logic [BUF_W-1:0] r_buf;
  logic            r_valid;
  logic            r_err;
  logic [15:0]     r_frame_cnt;
  field_t          r_fields;

  logic [BUF_W-1:0] w_buf_next;
  logic [CW-1:0]   w_beat_cnt;
  logic            w_is_last_beat;
  logic            w_accept;
  logic            w_collect;
  logic            w_cnt_en;
  logic            w_cnt_clr;
  field_t          w_fields_next;

  assign o_ready   = (r_state != ST_FULL);
  assign w_accept  = i_valid && o_ready;
  assign w_collect = w_accept && (r_state == ST_COLLECT);

  // Any collect beat that ends or breaks the frame resets the slot counter.
  assign w_cnt_en  = w_collect && !w_is_last_beat && !i_last;
  assign w_cnt_clr = w_collect && (w_is_last_beat || i_last);

  struct_beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (w_cnt_en),
    .i_clr     (w_cnt_clr),
    .o_cnt     (w_beat_cnt),
    .o_is_last (w_is_last_beat)
  );

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[int'(w_beat_cnt) * LANE_W +: LANE_W] = i_data;
  end

  // Lane bits above FW-1 in the final beat fall outside this slice.
  assign w_fields_next = field_t'(w_buf_next[FW-1:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_COLLECT;
      r_buf       <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
      r_fields    <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            if (!w_is_last_beat) begin
              if (i_last) begin
                r_err <= 1'b1;
              end else begin
                r_buf <= w_buf_next;
              end
            end else if (i_last) begin
              r_buf    <= w_buf_next;
              r_fields <= w_fields_next;
              r_valid  <= 1'b1;
              r_state  <= ST_FULL;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DISCARD;
            end
          end
        end
        ST_DISCARD: begin
          if (w_accept && i_last) begin
            r_state <= ST_COLLECT;
          end
        end
        ST_FULL: begin
          if (i_ready) begin
            r_valid     <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= ST_COLLECT;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

  assign o_valid     = r_valid;
  assign o_err       = r_err;
  assign o_frame_cnt = r_frame_cnt;
  assign o_d0        = r_fields.d0;
  assign o_d1        = r_fields.d1;

endmodule

// File: tb/tb_generic_struct_unpacker.sv
// Bench for generic_struct_unpacker: vector table, hand sequences for hold,
// reset, lane-width and wrap cases, then random frames against a frame model.
module tb_generic_struct_unpacker;

  localparam int W = 3;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid, i_data, i_last, i_ready;
  logic        o_ready, o_valid, o_err;
  logic        o_d0;
  logic [1:0]  o_d1;
  logic [15:0] o_frame_cnt;

  logic        i_valid_2, i_last_2, i_ready_2;
  logic [1:0]  i_data_2;
  logic        o_ready_2, o_valid_2, o_err_2;
  logic        o_d0_2;
  logic [1:0]  o_d1_2;
  logic [15:0] o_frame_cnt_2;

  generic_struct_unpacker dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_d0(o_d0), .o_d1(o_d1), .o_err(o_err), .o_frame_cnt(o_frame_cnt)
  );

  generic_struct_unpacker #(.W0(1), .W1(2), .LANE_W(2)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid_2), .o_ready(o_ready_2),
    .i_data(i_data_2), .i_last(i_last_2), .o_valid(o_valid_2), .i_ready(i_ready_2),
    .o_d0(o_d0_2), .o_d1(o_d1_2), .o_err(o_err_2), .o_frame_cnt(o_frame_cnt_2)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- observer / scoreboard ----------------
  int          valid_pulses, err_pulses, err_consec;
  logic        cap_d0;
  logic [1:0]  cap_d1;
  logic        prev_err = 1'b0;
  bit          mon_en = 1'b0;
  int          obs_rnd_err = 0;
  logic [15:0] model_cnt;
  logic [W-1:0] exp_q[$];

  always @(negedge i_clk) begin
    if (o_valid) begin
      valid_pulses++;
      cap_d0 = o_d0;
      cap_d1 = o_d1;
    end
    if (o_err) begin
      err_pulses++;
      if (prev_err) err_consec++;
      if (mon_en) obs_rnd_err++;
    end
    prev_err = o_err;
    if (mon_en && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("rnd_unexpected_frame", 32'd1, 32'd0);
      end else begin
        check("rnd_frame", {29'd0, o_d0, o_d1}, {29'd0, exp_q.pop_front()});
        check("rnd_frame_cnt", {16'd0, o_frame_cnt}, {16'd0, model_cnt});
        model_cnt = model_cnt + 16'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic d, input logic l);
    bit acc;
    bit ok;
    ok      = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    for (int t = 0; t < 64; t++) begin
      acc = o_ready;
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  beats;
    int          len;
    int          err_after;
    bit          exp_valid;
    logic        exp_d0;
    logic [1:0]  exp_d1;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic run_row(input int r);
    vec_t v;
    v = vecs[r];
    valid_pulses = 0;
    err_pulses   = 0;
    err_consec   = 0;
    for (int k = 0; k < v.len; k++) begin
      send_beat(v.beats[k], (k == v.len - 1));
      if (k == v.err_after)
        check($sformatf("row%0d_err_timing", r), {31'd0, o_err}, 32'd1);
      if (k == v.len - 1 && v.exp_valid)
        check($sformatf("row%0d_latency", r), {31'd0, o_valid}, 32'd1);
    end
    repeat (3) step();
    check($sformatf("row%0d_valid_pulses", r), valid_pulses, v.exp_valid ? 1 : 0);
    check($sformatf("row%0d_err_pulses", r), err_pulses, (v.err_after >= 0) ? 1 : 0);
    check($sformatf("row%0d_err_consec", r), err_consec, 0);
    check($sformatf("row%0d_frame_cnt", r), {16'd0, o_frame_cnt}, {16'd0, v.exp_cnt});
    if (v.exp_valid) begin
      check($sformatf("row%0d_d0", r), {31'd0, cap_d0}, {31'd0, v.exp_d0});
      check($sformatf("row%0d_d1", r), {30'd0, cap_d1}, {30'd0, v.exp_d1});
    end
  endtask

  // ---------------- random ready driver ----------------
  bit rnd_run = 1'b0;

  initial begin
    wait (rnd_run);
    while (rnd_run) begin
      @(posedge i_clk);
      #1;
      i_ready = ($urandom_range(0, 3) != 0);
    end
    i_ready = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int model_err;
    int len;
    logic [4:0] fb;
    logic [W-1:0] vec;

    // beats are listed bit k = beat k
    vecs[0] = '{4'b0101, 3, -1, 1'b1, 1'b1, 2'b01, 16'd1};
    vecs[1] = '{4'b0011, 2,  1, 1'b0, 1'b0, 2'b00, 16'd1};
    vecs[2] = '{4'b0110, 3, -1, 1'b1, 1'b1, 2'b10, 16'd2};
    vecs[3] = '{4'b1101, 4,  2, 1'b0, 1'b0, 2'b00, 16'd2};
    vecs[4] = '{4'b0011, 3, -1, 1'b1, 1'b0, 2'b11, 16'd3};
    vecs[5] = '{4'b0100, 3, -1, 1'b1, 1'b1, 2'b00, 16'd1};
    vecs[6] = '{4'b0101, 3, -1, 1'b1, 1'b1, 2'b01, 16'd0};

    i_rst = 1'b1;
    i_valid = 1'b0; i_data = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    i_valid_2 = 1'b0; i_data_2 = 2'b00; i_last_2 = 1'b0; i_ready_2 = 1'b0;
    repeat (2) step();
    i_rst = 1'b0;
    step();

    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_ready", {31'd0, o_ready}, 32'd1);
    check("reset_err", {31'd0, o_err}, 32'd0);
    check("reset_d0", {31'd0, o_d0}, 32'd0);
    check("reset_d1", {30'd0, o_d1}, 32'd0);
    check("reset_frame_cnt", {16'd0, o_frame_cnt}, 32'd0);

    for (int r = 0; r < 5; r++) run_row(r);

    // Consumer stall: struct must hold and input must stay blocked.
    i_ready = 1'b0;
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    send_beat(1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", {31'd0, o_valid}, 32'd1);
      check("hold_ready", {31'd0, o_ready}, 32'd0);
      check("hold_d0", {31'd0, o_d0}, 32'd1);
      check("hold_d1", {30'd0, o_d1}, 32'd1);
      step();
    end
    i_ready = 1'b1;
    step();
    check("hold_release_valid", {31'd0, o_valid}, 32'd0);
    check("hold_release_ready", {31'd0, o_ready}, 32'd1);
    check("hold_release_cnt", {16'd0, o_frame_cnt}, 32'd4);

    // Reset part-way through a frame.
    send_beat(1'b1, 1'b0);
    send_beat(1'b1, 1'b0);
    i_rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_ready", {31'd0, o_ready}, 32'd1);
    check("midrst_cnt", {16'd0, o_frame_cnt}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    step();
    run_row(5);

    // Two-bit lane: the top bit of the final beat is ignored.
    check("lane2_ready", {31'd0, o_ready_2}, 32'd1);
    i_valid_2 = 1'b1; i_data_2 = 2'b10; i_last_2 = 1'b0;
    step();
    i_data_2 = 2'b11; i_last_2 = 1'b1;
    step();
    i_valid_2 = 1'b0; i_last_2 = 1'b0;
    check("lane2_valid", {31'd0, o_valid_2}, 32'd1);
    check("lane2_d0", {31'd0, o_d0_2}, 32'd1);
    check("lane2_d1", {30'd0, o_d1_2}, 32'd2);
    check("lane2_err", {31'd0, o_err_2}, 32'd0);
    i_ready_2 = 1'b1;
    step();
    check("lane2_cnt", {16'd0, o_frame_cnt_2}, 32'd1);

    // Frame counter wrap from 0xFFFF.
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    #1;
    check("wrap_preload", {16'd0, o_frame_cnt}, 32'h0000FFFF);
    step();
    run_row(6);

    // Random frames against a frame-level model.
    model_cnt = 16'h0000;
    model_err = 0;
    mon_en  = 1'b1;
    rnd_run = 1'b1;
    for (int f = 0; f < 80; f++) begin
      len = ($urandom_range(0, 9) < 6) ? 3 : $urandom_range(1, 5);
      fb  = 5'($urandom_range(0, 31));
      if (len == 3) begin
        for (int k = 0; k < W; k++) vec[k] = fb[k];
        exp_q.push_back(vec);
      end else begin
        model_err++;
      end
      for (int k = 0; k < len; k++) send_beat(fb[k], (k == len - 1));
      repeat ($urandom_range(0, 2)) step();
    end
    rnd_run = 1'b0;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) step();
    repeat (2) step();
    mon_en = 1'b0;
    check("rnd_drain", exp_q.size(), 0);
    check("rnd_err_count", obs_rnd_err, model_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
